// File: rtl/adc_sample_pipe_if.sv
// Valid/ready sample stream bundle.
// The producer drives data/valid and the consumer drives ready.
interface adc_sample_pipe_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/adc_sample_pipe.sv
// DEPTH-stage registered ADC sample pipe.
// Provides valid/ready on both sides, bubble collapse, freeze, flush and occupancy.
module adc_sample_pipe #(
  parameter int              DATA_W    = 12,
  parameter int              DEPTH     = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         flush,
  adc_sample_pipe_if.slave             in_s,
  adc_sample_pipe_if.master            out_m,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  free;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  logic out_valid;
  logic in_ready;
  logic pop;
  logic accept;

  always_comb begin
    out_valid = valid_q[DEPTH-1] && enable && reset_n;
    pop       = out_valid && out_m.ready;
    // A stage is free if it is empty or its word moves on this cycle.
    free[DEPTH-1] = !valid_q[DEPTH-1] || pop;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      free[k] = !valid_q[k] || free[k+1];
    end
    in_ready = reset_n && enable && !flush && free[0];
    accept   = in_s.valid && in_ready;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (enable) begin
      if (free[0]) begin
        valid_d[0] = accept;
        if (accept) begin
          data_d[0] = in_s.data;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (free[k]) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      data_q  <= data_d;
    end
  end

  assign in_s.ready  = in_ready;
  assign out_m.valid = out_valid;
  assign out_m.data  = data_q[DEPTH-1];
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_adc_sample_pipe.sv
// Directed plus randomized bench for adc_sample_pipe.
// A queue-with-age reference model predicts handshakes, data and occupancy.
module tb_adc_sample_pipe;

  localparam int DW = 12;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          flush = 1'b0;
  logic [2:0]    occupancy;

  adc_sample_pipe_if #(.DATA_W(DW)) in_if ();
  adc_sample_pipe_if #(.DATA_W(DW)) out_if ();

  adc_sample_pipe #(
    .DATA_W    (DW),
    .DEPTH     (D),
    .RESET_VAL (12'h000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .flush     (flush),
    .in_s      (in_if),
    .out_m     (out_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit seen_edge = 0;
  bit last_acc = 0;

  logic [DW-1:0] mq_data [$];
  int            mq_age  [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    bit            exp_ov;
    bit            exp_pop;
    bit            exp_ir;
    bit            acc;
    logic [DW-1:0] acc_data;
    @(negedge clk);
    exp_ov  = reset_n && enable && mq_data.size() > 0 && mq_age[0] >= D - 1;
    exp_pop = exp_ov && out_if.ready;
    exp_ir  = reset_n && enable && !flush &&
              (mq_data.size() < D || exp_pop);
    if (seen_edge) begin
      chk("occupancy", 32'(occupancy), 32'(mq_data.size()));
    end
    chk("in_ready", 32'(in_if.ready), 32'(exp_ir));
    chk("out_valid", 32'(out_if.valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_data", 32'(out_if.data), 32'(mq_data[0]));
    end
    acc      = exp_ir && in_if.valid;
    acc_data = in_if.data;
    @(posedge clk);
    seen_edge = 1;
    if (!reset_n || flush) begin
      mq_data.delete();
      mq_age.delete();
    end else if (enable) begin
      if (exp_pop) begin
        void'(mq_data.pop_front());
        void'(mq_age.pop_front());
      end
      foreach (mq_age[i]) mq_age[i]++;
      if (acc) begin
        mq_data.push_back(acc_data);
        mq_age.push_back(0);
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] first, input int n,
                      input int max_cyc);
    logic [DW-1:0] w;
    int k;
    int c;
    w = first;
    k = 0;
    c = 0;
    in_if.valid = 1'b1;
    while (k < n && c < max_cyc) begin
      in_if.data = w;
      cycle();
      if (last_acc) begin
        w++;
        k++;
      end
      c++;
    end
    in_if.valid = 1'b0;
    chk("send_done", 32'(k), 32'(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    in_if.valid  = 1'b1;
    in_if.data   = 12'hABC;
    out_if.ready = 1'b1;

    // Reset held two cycles with a live input word.
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    in_if.valid = 1'b0;
    @(negedge clk);
    chk("rst_out_data", 32'(out_if.data), 32'h000);
    chk("rst_occ", 32'(occupancy), 32'd0);
    idle(1);

    // Back-to-back streaming.
    out_if.ready = 1'b1;
    send(12'h001, 16, 40);
    idle(6);

    // Back-pressure fill, then release.
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = 12'h100;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) in_if.data = in_if.data + 12'd1;
    end
    chk("bp_occ", 32'(occupancy), 32'd4);
    chk("bp_head", 32'(out_if.data), 32'h100);
    out_if.ready = 1'b1;
    send(in_if.data, 2, 20);
    idle(6);

    // Full pipe with simultaneous push and pop.
    out_if.ready = 1'b0;
    send(12'h200, 4, 20);
    out_if.ready = 1'b1;
    send(12'h204, 6, 20);
    idle(6);

    // Freeze mid-stream.
    in_if.valid = 1'b1;
    in_if.data  = 12'h300;
    for (int i = 0; i < 12; i++) begin
      enable = !(i >= 5 && i < 8);
      cycle();
      if (last_acc) in_if.data = in_if.data + 12'd1;
    end
    enable = 1'b1;
    in_if.valid = 1'b0;
    idle(6);

    // Flush with three words held.
    out_if.ready = 1'b0;
    send(12'h400, 3, 10);
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    out_if.ready = 1'b1;
    send(12'h7FF, 1, 5);
    idle(6);

    // Reset while stalled with two words held.
    out_if.ready = 1'b0;
    send(12'h500, 2, 10);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("midrst_occ", 32'(occupancy), 32'd0);
    out_if.ready = 1'b1;
    send(12'h600, 5, 20);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_if.valid  = ($urandom_range(0, 9) < 6);
      in_if.data   = DW'($urandom);
      out_if.ready = ($urandom_range(0, 9) < 6);
      enable       = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 49) == 0);
      reset_n      = ($urandom_range(0, 79) != 0);
      cycle();
    end
    reset_n = 1'b1;
    flush = 1'b0;
    enable = 1'b1;
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_sample_pipe.md
Name: adc_sample_pipe

Overview:
- Parametrised successor to the team's single-bit enable flip-flop.
- A DATA_W-bit, DEPTH-stage registered pipeline for ADC sample words, using valid/ready handshakes on both sides.
- Per-stage valid bits, bubble collapsing, a global clock-enable (freeze), synchronous flush and an occupancy count.
- Sits between the SAR conversion logic and downstream filtering/packetisation; absorbs short downstream stalls without losing samples.

Parameters:
DATA_W, 12, sample word width in bits (>=1)
DEPTH, 4, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data stage on reset

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  synchronous, active-low reset
enable  input  1  global enable; 0 freezes all state
flush  input  1  synchronous clear of all valid bits
in_data  input  DATA_W  incoming sample
in_valid  input  1  in_data valid
in_ready  output  1  pipe accepts in_data this cycle
out_data  output  DATA_W  data of last stage (DEPTH-1)
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
occupancy  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

Behaviour:
- Reset priority: reset_n=0 at a rising edge overrides everything.
  - Clears all valid bits; sets all data stages to RESET_VAL; sets occupancy to 0.
  - Applies mid-transfer; in-flight words are lost.
  - While reset_n=0: in_ready=0, out_valid=0.
- Priority order: reset > flush > enable > normal operation.
- Stage k holds data[k] and valid[k]; stage 0 is the input stage, stage DEPTH-1 drives out_data/out_valid.
- Stage movement, evaluated combinationally from the output end backwards:
  - pop = out_valid && out_ready.
  - free[DEPTH-1] = !valid[DEPTH-1] || pop.
  - free[k] = !valid[k] || (valid[k] && free[k+1]) for k < DEPTH-1.
  - Stage k loads from stage k-1 when free[k] && valid[k-1]; stage 0 loads from in_data.
  - A stage that moves out and receives nothing clears its valid bit.
- in_ready = reset_n && enable && !flush && free[0]. This is combinational, so a full pipe with out_ready=1 still accepts 1 word/cycle.
- out_valid = valid[DEPTH-1] && enable && reset_n. out_data always shows data[DEPTH-1].
- Latency: with an empty pipe and no stalls, a word accepted in cycle t appears with out_valid=1 in cycle t+DEPTH.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Bubble collapse: with out_ready=0, valid words advance into empty downstream stages until contiguous at the output end. A full pipe holds DEPTH words.
- enable=0: no register changes (data, valid, occupancy); in_ready=0, out_valid=0, so no transfer occurs. Resumes exactly where it left off.
- flush=1 (reset_n=1):
  - Clears all valid bits and occupancy at the edge, regardless of enable.
  - Data registers keep their values.
  - in_ready=0 and out_valid is unaffected combinationally, but no pop is counted during flush: the word is discarded.
- Occupancy: registered; next = occupancy + accept - pop, where accept = in_valid && in_ready.
  - Simultaneous accept and pop leaves it unchanged.
  - Never exceeds DEPTH and never underflows.
- Data is never modified in flight: out_data equals in_data bit-exact, in acceptance order. No duplication, no drop, except on reset or flush.
- Degenerate DEPTH=1: single register; full and out_ready=1 gives same-cycle replace (accept and pop together).

Test Plan (DATA_W=12, DEPTH=4):
1. Reset: hold reset_n=0 for 2 cycles with in_valid=1, in_data=12'hABC -> in_ready=0, out_valid=0, occupancy=0; after release, out_data=RESET_VAL=0 until the first word arrives.
2. Streaming: out_ready=1, enable=1; send 0x001..0x010 back to back -> first out_valid 4 cycles after first accept; 16 words out in order, 1/cycle; occupancy steady at 4 during the stream.
3. Back-pressure/fill: out_ready=0; send 0x100..0x105 -> words 0x100..0x103 accepted; in_ready=0 from the cycle occupancy reaches 4; out_data=0x100. Raise out_ready -> 0x100..0x103 drain, then 0x104 and 0x105 are accepted (held in_valid), with no loss or duplication.
4. Full plus simultaneous push/pop: pipe full, out_ready=1, in_valid=1 -> in_ready=1 that same cycle; occupancy stays 4; order preserved.
5. Freeze and flush: enable=0 for 3 cycles mid-stream -> no outputs, state unchanged, then resumes the same sequence. flush=1 one cycle with occupancy=3 -> occupancy=0 next cycle, out_valid=0, the next accepted word 0x7FF exits after 4 cycles.
6. Reset mid-operation: reset_n=0 for 1 cycle with occupancy=2 and the pipe stalled -> all valid bits clear; occupancy=0; subsequent traffic starts fresh.
